histeq_ctrl: RTL

HISTEQ_CTRL -- requirements
Module: histeq_ctrl

---
 rtl/histeq_ctrl_pkg.sv | 17 +
 rtl/cdf_scaler.sv | 79 +++++++
 rtl/histeq_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/histeq_ctrl_pkg.sv
// Shared histogram-equalisation definitions: default widths and controller state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package histeq_ctrl_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int PIXEL_COUNT_WIDTH = 18;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_SCAN    = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_COMMIT  = 3'd4
    } state_e;

endpackage

// File: rtl/cdf_scaler.sv
// Running cdf over histogram read-back, scaled to the output level range and clamped.
// Latency: entry k is presented 2 cycles after bin k is read (1 memory + 1 accumulate).
// Backpressure: none; follows the read strobe unconditionally.
//
// Ports: i_start clears the cdf for a new scan; i_rd/i_addr mirror the histogram read;
// i_hist_data returns one cycle after i_rd; o_wr_vld/o_wr_addr/o_wr_dat write one shadow entry.
module cdf_scaler
    import histeq_ctrl_pkg::*;
#(
    parameter int DataWidth       = DATA_WIDTH,
    parameter int numIntLevels    = 2**DataWidth,
    parameter int PixelCountWidth = PIXEL_COUNT_WIDTH
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_start,
    input  logic                       i_rd,
    input  logic [DataWidth-1:0]       i_addr,
    input  logic [PixelCountWidth:0]   i_hist_data,
    output logic                       o_wr_vld,
    output logic [DataWidth-1:0]       o_wr_addr,
    output logic [DataWidth-1:0]       o_wr_dat
);

    localparam int CdfWidth  = PixelCountWidth + 1;
    localparam int ProdWidth = CdfWidth + DataWidth;
    localparam logic [CdfWidth-1:0]  CdfMax   = {1'b1, {PixelCountWidth{1'b0}}};
    localparam logic [DataWidth-1:0] MaxLevel = DataWidth'(numIntLevels - 1);

    logic                 rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DataWidth-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic [CdfWidth-1:0]  cdf_q, cdf_d;
    logic [CdfWidth:0]    sum;
    logic [ProdWidth-1:0] prod;
    logic [DataWidth:0]   scaled;

    always_comb begin
        // Stage 1 marks the cycle the bin count is on i_hist_data,
        // stage 2 the cycle the updated cdf is ready to scale.
        rd1_d   = i_rd;
        addr1_d = i_addr;
        rd2_d   = rd1_q;
        addr2_d = addr1_q;

        sum   = {1'b0, cdf_q} + {1'b0, i_hist_data};
        cdf_d = cdf_q;
        if (i_start) begin
            cdf_d = '0;
        end else if (rd1_q) begin
            cdf_d = (sum > {1'b0, CdfMax}) ? CdfMax : sum[CdfWidth-1:0];
        end

        // (cdf * (levels-1)) >> PixelCountWidth; one guard bit above the entry
        // width lets the clamp catch anything past the top level.
        prod     = ProdWidth'(cdf_q) * ProdWidth'(MaxLevel);
        scaled   = prod[PixelCountWidth +: DataWidth+1];
        o_wr_dat = (scaled > {1'b0, MaxLevel}) ? MaxLevel : scaled[DataWidth-1:0];
    end

    assign o_wr_vld  = rd2_q;
    assign o_wr_addr = addr2_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd1_q   <= 1'b0;
            rd2_q   <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            cdf_q   <= '0;
        end else begin
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            cdf_q   <= cdf_d;
        end
    end

endmodule

// File: rtl/histeq_ctrl.sv
// Histogram-equalisation controller: counts a frame, scans/clears the histogram, builds and commits the LUT.
// Latency: accepted last pixel to o_frame_done is numIntLevels+3 cycles; map visible the cycle after.
// Backpressure: o_pixel_ready drops for the whole scan/drain/commit window; the source must stall.
//
// Ports: i_enable run request; i_pixel_valid/i_pixel_last observed stream; o_pixel_ready stall;
// o_hist_rd/o_hist_clr/o_hist_addr read-and-clear port, i_hist_data one cycle later;
// o_map_domain packed LUT (entry k at [k*DataWidth +: DataWidth]); o_map_enable mapper enable;
// o_frame_done commit pulse; o_size_err sticky frame-size error.
module histeq_ctrl
    import histeq_ctrl_pkg::*;
#(
    parameter int DataWidth       = DATA_WIDTH,
    parameter int numIntLevels    = 2**DataWidth,
    parameter int PixelCountWidth = PIXEL_COUNT_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_pixel_valid,
    input  logic                              i_pixel_last,
    output logic                              o_pixel_ready,
    output logic                              o_hist_rd,
    output logic                              o_hist_clr,
    output logic [DataWidth-1:0]              o_hist_addr,
    input  logic [PixelCountWidth:0]          i_hist_data,
    output logic [DataWidth*numIntLevels-1:0] o_map_domain,
    output logic                              o_map_enable,
    output logic                              o_frame_done,
    output logic                              o_size_err
);

    // Two spare bits so an oversized frame cannot wrap back onto the expected size.
    localparam int CntWidth = PixelCountWidth + 2;
    localparam logic [CntWidth-1:0]  FrameSize = {2'b01, {PixelCountWidth{1'b0}}};
    localparam logic [DataWidth-1:0] LastAddr  = DataWidth'(numIntLevels - 1);

    state_e                                    state_q, state_d;
    logic [CntWidth-1:0]                       pix_cnt_q, pix_cnt_d, pix_cnt_inc;
    logic                                      size_err_q, size_err_d;
    logic [DataWidth-1:0]                      addr_q, addr_d;
    logic                                      drain_q, drain_d;
    logic                                      map_valid_q, map_valid_d;
    logic [numIntLevels-1:0][DataWidth-1:0]    shadow_q, shadow_d;
    logic [numIntLevels-1:0][DataWidth-1:0]    map_q, map_d;
    logic [numIntLevels-1:0][DataWidth-1:0]    ident;
    logic                                      last_acc;
    logic                                      wr_vld;
    logic [DataWidth-1:0]                      wr_addr, wr_dat;

    // ready is always high in COLLECT, so valid alone qualifies acceptance there.
    assign last_acc = (state_q == ST_COLLECT) && i_pixel_valid && i_pixel_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (i_enable) state_d = ST_COLLECT;
            ST_COLLECT: if (last_acc) state_d = ST_SCAN;
            ST_SCAN:    if (addr_q == LastAddr) state_d = ST_DRAIN;
            // Two cycles: the last bin's data returns, then its scaled entry is written.
            ST_DRAIN:   if (drain_q) state_d = ST_COMMIT;
            ST_COMMIT:  state_d = i_enable ? ST_COLLECT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_pixel_ready = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
        o_hist_rd     = (state_q == ST_SCAN);
        o_hist_clr    = (state_q == ST_SCAN);
        o_frame_done  = (state_q == ST_COMMIT);
        o_map_enable  = map_valid_q && (state_q == ST_COLLECT);
    end

    assign o_hist_addr  = addr_q;
    assign o_size_err   = size_err_q;
    assign o_map_domain = map_q;

    cdf_scaler #(
        .DataWidth       (DataWidth),
        .numIntLevels    (numIntLevels),
        .PixelCountWidth (PixelCountWidth)
    ) u_cdf_scaler (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (last_acc),
        .i_rd        (o_hist_rd),
        .i_addr      (addr_q),
        .i_hist_data (i_hist_data),
        .o_wr_vld    (wr_vld),
        .o_wr_addr   (wr_addr),
        .o_wr_dat    (wr_dat)
    );

    always_comb begin
        for (int k = 0; k < numIntLevels; k++) begin
            ident[k] = DataWidth'(k);
        end
    end

    // ---------------- counters and tables ----------------
    always_comb begin
        pix_cnt_inc = (&pix_cnt_q) ? pix_cnt_q : pix_cnt_q + CntWidth'(1);
        pix_cnt_d   = pix_cnt_q;
        size_err_d  = size_err_q;
        if ((state_q == ST_COLLECT) && i_pixel_valid) begin
            // The last pixel is included in the size check, then the count restarts.
            pix_cnt_d = i_pixel_last ? '0 : pix_cnt_inc;
            if (i_pixel_last && (pix_cnt_inc != FrameSize)) begin
                size_err_d = 1'b1;
            end
        end

        addr_d = addr_q;
        if (state_q == ST_SCAN) begin
            addr_d = (addr_q == LastAddr) ? '0 : addr_q + DataWidth'(1);
        end

        drain_d     = (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
        map_valid_d = map_valid_q || (state_q == ST_COMMIT);

        shadow_d = shadow_q;
        if (wr_vld) begin
            shadow_d[wr_addr] = wr_dat;
        end

        // The visible map only ever changes here, as a whole.
        map_d = (state_q == ST_COMMIT) ? shadow_q : map_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pix_cnt_q   <= '0;
            size_err_q  <= 1'b0;
            addr_q      <= '0;
            drain_q     <= 1'b0;
            map_valid_q <= 1'b0;
            shadow_q    <= ident;
            map_q       <= ident;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            size_err_q  <= size_err_d;
            addr_q      <= addr_d;
            drain_q     <= drain_d;
            map_valid_q <= map_valid_d;
            shadow_q    <= shadow_d;
            map_q       <= map_d;
        end
    end

endmodule
